// File: rtl/tartaruga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tartaruga_pkg
// Description : Shared types and constants for the tartaruga pipeline
//               (writeback bundle, bus and register-index types).
// Revision    : 1.0 - initial release
// ============================================================================
package tartaruga_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [31:0] bus32_t;
  typedef logic [4:0]  reg_idx_t;

  // Decoded-instruction fields the writeback stage cares about
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     regfile_we;
  } instr_t;

  // Bundle handed from the memory stage to writeback
  typedef struct packed {
    instr_t instr;
    bus32_t result;
    logic   branch_taken;
  } mem_to_wb_t;

endpackage : tartaruga_pkg
`default_nettype wire

// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_if
// Description : Bus bundle between the pipeline and the writeback/regfile
//               block: memory-stage input, decode read ports and writeback
//               status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_regfile_if;
  import tartaruga_pkg::*;

  mem_to_wb_t  mem_to_wb_i;
  reg_idx_t    rs1_addr_i;
  reg_idx_t    rs2_addr_i;
  bus32_t      rs1_data_o;
  bus32_t      rs2_data_o;
  logic        wb_we_o;
  reg_idx_t    wb_rd_o;
  bus32_t      wb_data_o;
  logic [63:0] instret_o;
  logic        branch_retired_o;

  // Pipeline side: drives the bundle and read addresses
  modport master (
    output mem_to_wb_i, rs1_addr_i, rs2_addr_i,
    input  rs1_data_o, rs2_data_o, wb_we_o, wb_rd_o, wb_data_o,
           instret_o, branch_retired_o
  );

  // Writeback/regfile side
  modport slave (
    input  mem_to_wb_i, rs1_addr_i, rs2_addr_i,
    output rs1_data_o, rs2_data_o, wb_we_o, wb_rd_o, wb_data_o,
           instret_o, branch_retired_o
  );
endinterface : wb_regfile_if
`default_nettype wire

// File: rtl/wb_regfile_regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : Architectural register array, two combinational read ports
//               with write-through bypass, one synchronous write port,
//               index 0 hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile
  import tartaruga_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  wire logic            clk_i,
  input  wire logic            rstn_i,
  input  wire logic            i_we,
  input  wire reg_idx_t        i_waddr,
  input  wire logic [XLEN-1:0] i_wdata,
  input  wire reg_idx_t        i_raddr1,
  input  wire reg_idx_t        i_raddr2,
  output logic      [XLEN-1:0] o_rdata1,
  output logic      [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [NUM_REGS];

  // Write port: entry 0 is never loaded so it stays at its reset value of 0
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_we && (i_waddr == reg_idx_t'(i))) r_regs[i] <= i_wdata;
      end
    end
  end

  // Read ports: x0 wins over bypass, bypass wins over stored contents
  always_comb begin
    o_rdata1 = r_regs[i_raddr1];
    o_rdata2 = r_regs[i_raddr2];
    if (i_we && (i_raddr1 == i_waddr)) o_rdata1 = i_wdata;
    if (i_we && (i_raddr2 == i_waddr)) o_rdata2 = i_wdata;
    if (i_raddr1 == '0) o_rdata1 = '0;
    if (i_raddr2 == '0) o_rdata2 = '0;
  end

endmodule : regfile
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Writeback stage wrapper: commit decode, register file,
//               retired-instruction counter and taken-branch pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
  import tartaruga_pkg::*;
#(
  parameter int NUM_REGS = tartaruga_pkg::NUM_REGS,
  parameter int XLEN     = 32
) (
  input  wire logic  clk_i,
  input  wire logic  rstn_i,
  wb_regfile_if.slave bus
);

  logic        w_valid;
  logic        w_commit;
  logic [63:0] r_instret;

  assign w_valid  = bus.mem_to_wb_i.instr.valid;
  // rd == 0 is filtered here so x0 never shows up as a write to consumers
  assign w_commit = w_valid & bus.mem_to_wb_i.instr.regfile_we
                  & (bus.mem_to_wb_i.instr.rd != '0);

  regfile #(
    .NUM_REGS (NUM_REGS),
    .XLEN     (XLEN)
  ) u_regfile (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .i_we     (w_commit),
    .i_waddr  (bus.mem_to_wb_i.instr.rd),
    .i_wdata  (bus.mem_to_wb_i.result),
    .i_raddr1 (bus.rs1_addr_i),
    .i_raddr2 (bus.rs2_addr_i),
    .o_rdata1 (bus.rs1_data_o),
    .o_rdata2 (bus.rs2_data_o)
  );

  // Retired-instruction counter: every valid bundle counts, wraps mod 2^64
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      r_instret <= '0;
    else if (w_valid) r_instret <= r_instret + 64'd1;
  end

  assign bus.wb_we_o          = w_commit;
  assign bus.wb_rd_o          = bus.mem_to_wb_i.instr.rd;
  assign bus.wb_data_o        = bus.mem_to_wb_i.result;
  assign bus.instret_o        = r_instret;
  assign bus.branch_retired_o = w_valid & bus.mem_to_wb_i.branch_taken;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile: directed scenarios plus
//               randomized bundles against an array/counter reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;
  import tartaruga_pkg::*;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0]     m_regs [32];
  longint unsigned m_instret;

  wb_regfile_if bus ();

  wb_regfile #(.NUM_REGS(32), .XLEN(32)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  // Safety net so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit we, input logic [4:0] rd,
                       input logic [31:0] res, input bit br,
                       input logic [4:0] a1, input logic [4:0] a2);
    bus.mem_to_wb_i.instr.valid      = v;
    bus.mem_to_wb_i.instr.regfile_we = we;
    bus.mem_to_wb_i.instr.rd         = rd;
    bus.mem_to_wb_i.result           = res;
    bus.mem_to_wb_i.branch_taken     = br;
    bus.rs1_addr_i                   = a1;
    bus.rs2_addr_i                   = a2;
  endtask

  function automatic bit m_commit();
    return bus.mem_to_wb_i.instr.valid && bus.mem_to_wb_i.instr.regfile_we
        && (bus.mem_to_wb_i.instr.rd != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_commit() && a == bus.mem_to_wb_i.instr.rd) return bus.mem_to_wb_i.result;
    return m_regs[a];
  endfunction

  // Compare every combinational output against the model
  task automatic check_comb(input string tag);
    chk({tag, ".rs1"}, 64'(bus.rs1_data_o), 64'(m_read(bus.rs1_addr_i)));
    chk({tag, ".rs2"}, 64'(bus.rs2_data_o), 64'(m_read(bus.rs2_addr_i)));
    chk({tag, ".we"}, 64'(bus.wb_we_o), 64'(m_commit()));
    chk({tag, ".rd"}, 64'(bus.wb_rd_o), 64'(bus.mem_to_wb_i.instr.rd));
    chk({tag, ".wdata"}, 64'(bus.wb_data_o), 64'(bus.mem_to_wb_i.result));
    chk({tag, ".br"}, 64'(bus.branch_retired_o),
        64'(bus.mem_to_wb_i.instr.valid && bus.mem_to_wb_i.branch_taken));
    chk({tag, ".instret"}, bus.instret_o, m_instret);
  endtask

  // Clock edge: update the model from the bundle sampled at that edge
  task automatic tick();
    @(posedge clk_i);
    if (!rstn_i) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_instret = 0;
    end else begin
      if (m_commit()) m_regs[bus.mem_to_wb_i.instr.rd] = bus.mem_to_wb_i.result;
      if (bus.mem_to_wb_i.instr.valid) m_instret = m_instret + 1;
    end
    #1;
  endtask

  task automatic step(input string tag, input bit v, input bit we,
                      input logic [4:0] rd, input logic [31:0] res, input bit br,
                      input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk_i);
    drive(v, we, rd, res, br, a1, a2);
    #1;
    check_comb(tag);
    tick();
    chk({tag, ".post_instret"}, bus.instret_o, m_instret);
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    m_instret = 0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset: every index reads zero on both ports
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr_i = 5'(i);
      bus.rs2_addr_i = 5'(31 - i);
      #1;
      chk("reset.rs1", 64'(bus.rs1_data_o), 64'd0);
      chk("reset.rs2", 64'(bus.rs2_data_o), 64'd0);
    end
    chk("reset.instret", bus.instret_o, 64'd0);

    // Write rd=5 with same-cycle bypass on rs2, then read back via the array
    step("wr5", 1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 5'd5, 5'd0);
    #1;
    chk("wr5.readback", 64'(bus.rs1_data_o), 64'h0000_0000_DEAD_BEEF);
    chk("wr5.instret", bus.instret_o, 64'd1);

    // Bypass on both ports at once
    @(negedge clk_i);
    drive(1, 1, 5'd6, 32'hCAFE_F00D, 0, 5'd6, 5'd6);
    #1;
    chk("dualbyp.rs1", 64'(bus.rs1_data_o), 64'h0000_0000_CAFE_F00D);
    chk("dualbyp.rs2", 64'(bus.rs2_data_o), 64'h0000_0000_CAFE_F00D);
    tick();

    // x0 protection: no write, but the instruction still retires
    @(negedge clk_i);
    drive(1, 1, 5'd0, 32'h1234_5678, 0, 5'd0, 5'd0);
    #1;
    chk("x0.we", 64'(bus.wb_we_o), 64'd0);
    chk("x0.rs1_same", 64'(bus.rs1_data_o), 64'd0);
    chk("x0.rs2_same", 64'(bus.rs2_data_o), 64'd0);
    tick();
    chk("x0.instret", bus.instret_o, 64'd3);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0);
    #1;
    chk("x0.rs1_next", 64'(bus.rs1_data_o), 64'd0);

    // Invalid bundle: no write, no count, no pulse
    @(negedge clk_i);
    drive(0, 1, 5'd7, 32'hAAAA_5555, 1, 5'd7, 5'd7);
    #1;
    chk("inv.br", 64'(bus.branch_retired_o), 64'd0);
    chk("inv.we", 64'(bus.wb_we_o), 64'd0);
    chk("inv.rs1", 64'(bus.rs1_data_o), 64'd0);
    tick();
    #1;
    chk("inv.reg7", 64'(bus.rs1_data_o), 64'd0);
    chk("inv.instret", bus.instret_o, 64'd3);

    // Store-like retire: counts, writes nothing
    step("store", 1, 0, 5'd9, 32'h5A5A_5A5A, 0, 5'd9, 5'd5);
    chk("store.instret", bus.instret_o, 64'd4);

    // Counter wrap with taken branch
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0);
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("wrap.preload", bus.instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk_i);
    drive(1, 0, 5'd2, 32'h0, 1, 5'd5, 5'd6);
    #1;
    chk("wrap.pulse", 64'(bus.branch_retired_o), 64'd1);
    tick();
    chk("wrap.instret", bus.instret_o, 64'd0);
    @(negedge clk_i);
    drive(1, 0, 5'd2, 32'h0, 0, 5'd5, 5'd6);
    #1;
    chk("wrap.pulse_end", 64'(bus.branch_retired_o), 64'd0);
    tick();

    // Reset asserted on the edge of a pending write
    step("pre_rst", 1, 1, 5'd3, 32'h1, 0, 5'd3, 5'd0);
    @(negedge clk_i);
    drive(1, 1, 5'd4, 32'h2, 0, 5'd3, 5'd4);
    rstn_i = 1'b0;
    tick();
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 5'd3, 5'd4);
    rstn_i = 1'b1;
    #1;
    chk("rst_mid.reg3", 64'(bus.rs1_data_o), 64'd0);
    chk("rst_mid.reg4", 64'(bus.rs2_data_o), 64'd0);
    chk("rst_mid.instret", bus.instret_o, 64'd0);

    // Randomized traffic over a narrow index range to exercise bypass and x0
    for (int n = 0; n < 400; n++) begin
      step("rand",
           ($urandom_range(3) != 0),
           $urandom_range(1) == 1,
           5'($urandom_range(9)),
           $urandom,
           $urandom_range(1) == 1,
           5'($urandom_range(9)),
           ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(9)));
    end

    // Final sweep of the whole array
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr_i = 5'(i);
      bus.rs2_addr_i = 5'(i);
      #1;
      chk("sweep.rs1", 64'(bus.rs1_data_o), 64'(m_read(5'(i))));
      chk("sweep.rs2", 64'(bus.rs2_data_o), 64'(m_read(5'(i))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wb_regfile
`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage plus architectural register file for the tartaruga five-stage pipeline. Consumes the `mem_to_wb_t` bundle produced by the memory stage and commits `result` to the destination register. Serves the two decode-stage read ports with same-cycle write-through bypass. Maintains a 64-bit retired-instruction counter and exports the current writeback target for the hazard/forwarding logic.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural integer registers; index 0 is hardwired zero
- XLEN, 32, register data width; equals the width of `bus32_t`

Ports:
- clk_i  in  1  pipeline clock
- rstn_i  in  1  asynchronous active-low reset
- mem_to_wb_i  in  mem_to_wb_t  memory-stage bundle: `instr` (uses `valid`, `rd`, `regfile_we`), `result`, `branch_taken`
- rs1_addr_i  in  5  decode read port 1 index
- rs2_addr_i  in  5  decode read port 2 index
- rs1_data_o  out  XLEN  read port 1 data
- rs2_data_o  out  XLEN  read port 2 data
- wb_we_o  out  1  a register write happens this cycle
- wb_rd_o  out  5  destination index of that write
- wb_data_o  out  XLEN  data being written
- instret_o  out  64  count of retired instructions
- branch_retired_o  out  1  pulse: retiring instruction had `branch_taken` set

## Operation
- Commit condition: `commit = instr.valid & instr.regfile_we & (instr.rd != 0)`.
- On a clock edge with `commit`, `regs[rd] <= result`. Otherwise the array is unchanged.
- Register 0 is never written. Reads of index 0 return 0 regardless of bypass.
- Read ports are combinational:
  - If `commit` and `rsN_addr_i == rd`, return `result` (write-through bypass).
  - Otherwise return `regs[rsN_addr_i]`.
  - Both ports may bypass in the same cycle.
- `wb_we_o = commit`. `wb_rd_o` and `wb_data_o` pass through `rd` and `result` unconditionally. Consumers qualify them with `wb_we_o`.
- `instret_o` increments by 1 on every edge where `instr.valid` is high, whether or not a register is written (stores and branches count). It wraps modulo 2^64.
- `branch_retired_o = instr.valid & branch_taken`, combinational.
- An invalid bundle (`valid = 0`) causes no write, no count and no pulse, whatever the other fields hold.

## Timing
- Write latency: result is visible in the array one edge after it is presented. It is visible on the read ports in the same cycle through the bypass.
- Zero-cycle combinational path from `mem_to_wb_i` and `rsN_addr_i` to `rsN_data_o`.
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - All registers are 0.
  - `instret_o` is 0.
  - `wb_we_o`, `branch_retired_o` and the read data follow the combinational rules on reset contents. With a valid input during reset, outputs may show bypass values, but no state changes.
- Reset asserted mid-write: the write is discarded and the array returns to all-zero.
- Counter wrap: from 0xFFFF_FFFF_FFFF_FFFF a valid retire gives 0. There is no sticky overflow.

## Structure
- `tartaruga_pkg` owns:
  - `mem_to_wb_t` and `instr_t`, including the `valid`, `rd` and `regfile_we` fields.
  - `bus32_t`.
  - A new `reg_idx_t` (logic [4:0]).
  - A `NUM_REGS` constant.
- One sub-module, `regfile`:
  - 2 combinational read ports, 1 synchronous write port, x0 hardwired, bypass included.
  - The wrapper adds the commit decode, `instret` counter and branch pulse.

## Test plan
- Reset: assert `rstn_i` low, release, read all 32 indices on both ports -> every read returns 0 and `instret_o` = 0.
- Write/read:
  - Commit rd=5, result=0xDEADBEEF, then read rs1=5 next cycle -> 0xDEADBEEF, `instret_o` = 1.
  - Same cycle with rs2=5 -> bypass returns 0xDEADBEEF.
- x0 protection: commit rd=0, result=0x12345678 -> `wb_we_o` = 0; reads of index 0 return 0 in the same and next cycle; `instret_o` still increments.
- Invalid/no-write bundles:
  - valid=0, regfile_we=1, rd=7, result=0xAAAA5555 -> reg 7 unchanged, counter unchanged, `branch_retired_o` = 0.
  - valid=1, regfile_we=0 (store) -> counter +1, no write.
- Branch and wrap: preload `instret` to 2^64-1 by force, retire valid with branch_taken=1 -> `branch_retired_o` pulses 1 cycle, `instret_o` = 0.
- Reset mid-stream: commit rd=3=0x1, then rd=4=0x2 with reset asserted on that edge -> after release, regs 3 and 4 read 0 and `instret_o` = 0.
